// File: rtl/crc16_frame_tx_ctrl_pkg.sv
`default_nettype none
// -----------------------------------------------------------------------------
// crc16_frame_tx_ctrl_pkg : shared state encoding, CRC-16 constants and step fn
// Revision: 1.0 - initial release
// -----------------------------------------------------------------------------
package crc16_frame_tx_ctrl_pkg;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_FRAME = 3'd1,
      ST_TRAIL = 3'd2,
      ST_CLR   = 3'd3,
      ST_DROP  = 3'd4
   } state_e;

   localparam logic [15:0] CRC16_INIT        = 16'hFFFF;
   localparam logic [15:0] CRC16_POLY        = 16'h8005;
   localparam int unsigned MAX_WORDS_DEFAULT = 380;

   // MSB-first, unreflected: data bit 31 enters the register first.
   function automatic logic [15:0] crc16_next32(input logic [15:0] crc, input logic [31:0] data);
      logic [15:0] c;
      logic        fb;
      c = crc;
      for (int i = 31; i >= 0; i--) begin
         fb = c[15] ^ data[i];
         c  = {c[14:0], 1'b0} ^ (fb ? CRC16_POLY : 16'h0000);
      end
      return c;
   endfunction

endpackage
`default_nettype wire

// File: rtl/crc16_frame_tx_ctrl_crc16.sv
`default_nettype none
// -----------------------------------------------------------------------------
// crc16_frame_tx_ctrl_crc16 : 32-bit/cycle CRC-16 engine, clear wins over enable
// Revision: 1.0 - initial release
// -----------------------------------------------------------------------------
module crc16_frame_tx_ctrl_crc16
   import crc16_frame_tx_ctrl_pkg::*;
(
   input  logic        iClk,
   input  logic        iRst_n,
   input  logic        iEn,
   input  logic        iClr,
   input  logic [31:0] iData,
   output logic [15:0] oCrc
);

   logic [15:0] crc_q;
   logic [15:0] crc_d;

   always_comb begin
      crc_d = crc_q;
      if (iClr) begin
         crc_d = CRC16_INIT;
      end else if (iEn) begin
         crc_d = crc16_next32(crc_q, iData);
      end
   end

   always_ff @(posedge iClk or negedge iRst_n) begin
      if (!iRst_n) begin
         crc_q <= CRC16_INIT;
      end else begin
         crc_q <= crc_d;
      end
   end

   assign oCrc = crc_q;

endmodule
`default_nettype wire

// File: rtl/crc16_frame_tx_ctrl.sv
`default_nettype none
// -----------------------------------------------------------------------------
// crc16_frame_tx_ctrl : frame sequencer appending a CRC-16 trailer word per frame
// Optional statistics outputs when CRC16_FRAME_STAT_EN is defined.
// Revision: 1.0 - initial release
// -----------------------------------------------------------------------------
module crc16_frame_tx_ctrl
   import crc16_frame_tx_ctrl_pkg::*;
#(
   parameter int unsigned MAX_WORDS = MAX_WORDS_DEFAULT,
   parameter bit          TRAIL_HI  = 1'b0
)(
   input  logic        iClk,
   input  logic        iRst_n,
   input  logic [31:0] iData,
   input  logic        iValid,
   input  logic        iSop,
   input  logic        iEop,
   output logic        oReady,
   output logic [31:0] oData,
   output logic        oValid,
   output logic        oSop,
   output logic        oEop,
   input  logic        iReady,
   output logic        oProtoErr
`ifdef CRC16_FRAME_STAT_EN
   ,
   output logic [15:0] oFrameCnt,
   output logic [15:0] oErrCnt,
   output logic [15:0] oLastCrc
`endif
);

   localparam logic [15:0] MAX_W16 = 16'(MAX_WORDS);

   state_e      state_q, state_d;
   logic [15:0] count_q, count_d, w_count_inc;
   logic        drop_q, drop_d;
   logic [31:0] odata_q, odata_d;
   logic        ovalid_q, ovalid_d, osop_q, osop_d, oeop_q, oeop_d;
   logic        perr_q, perr_d;
   logic        w_out_free, w_ready, w_crc_en, w_crc_clr;
   logic [15:0] w_crc;
   logic [31:0] w_trailer;

   crc16_frame_tx_ctrl_crc16 u_crc (
      .iClk   (iClk),
      .iRst_n (iRst_n),
      .iEn    (w_crc_en),
      .iClr   (w_crc_clr),
      .iData  (iData),
      .oCrc   (w_crc)
   );

   generate
      if (TRAIL_HI) begin : g_trail_hi
         assign w_trailer = {w_crc, 16'h0000};
      end else begin : g_trail_lo
         assign w_trailer = {16'h0000, w_crc};
      end
   endgenerate

   assign w_out_free  = !ovalid_q || iReady;
   assign w_count_inc = count_q + 16'd1;

   always_comb begin
      state_d   = state_q;
      count_d   = count_q;
      drop_d    = drop_q;
      odata_d   = odata_q;
      osop_d    = osop_q;
      oeop_d    = oeop_q;
      ovalid_d  = ovalid_q && !iReady;
      perr_d    = 1'b0;
      w_crc_en  = 1'b0;
      w_crc_clr = 1'b0;
      w_ready   = 1'b0;
      unique case (state_q)
         ST_IDLE, ST_DROP: begin
            // A trailer may still be draining, so a new SOP must wait for the register.
            w_ready = (state_q == ST_DROP && !iSop) ? 1'b1 : w_out_free;
            if (iValid && w_ready) begin
               if (iSop) begin
                  ovalid_d = 1'b1;
                  odata_d  = iData;
                  osop_d   = 1'b1;
                  oeop_d   = 1'b0;
                  w_crc_en = 1'b1;
                  count_d  = 16'd1;
                  state_d  = iEop ? ST_TRAIL : ST_FRAME;
               end else if (state_q == ST_IDLE) begin
                  perr_d = 1'b1;
               end else if (iEop) begin
                  state_d = ST_IDLE;
               end
            end
         end
         ST_FRAME: begin
            if (iValid && iSop) begin
               perr_d  = 1'b1;
               state_d = ST_TRAIL;
            end else begin
               w_ready = w_out_free;
               if (iValid && w_out_free) begin
                  ovalid_d = 1'b1;
                  odata_d  = iData;
                  osop_d   = 1'b0;
                  oeop_d   = 1'b0;
                  w_crc_en = 1'b1;
                  count_d  = w_count_inc;
                  if (iEop) begin
                     state_d = ST_TRAIL;
                  end else if (w_count_inc == MAX_W16) begin
                     perr_d  = 1'b1;
                     drop_d  = 1'b1;
                     state_d = ST_TRAIL;
                  end
               end
            end
         end
         ST_TRAIL: begin
            // Trailer is latched here, so the engine may be cleared while it drains.
            if (w_out_free) begin
               ovalid_d = 1'b1;
               odata_d  = w_trailer;
               osop_d   = 1'b0;
               oeop_d   = 1'b1;
               state_d  = ST_CLR;
            end
         end
         ST_CLR: begin
            w_crc_clr = 1'b1;
            count_d   = 16'd0;
            drop_d    = 1'b0;
            state_d   = drop_q ? ST_DROP : ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge iClk or negedge iRst_n) begin
      if (!iRst_n) begin
         state_q  <= ST_IDLE;
         count_q  <= 16'd0;
         drop_q   <= 1'b0;
         odata_q  <= 32'd0;
         ovalid_q <= 1'b0;
         osop_q   <= 1'b0;
         oeop_q   <= 1'b0;
         perr_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         count_q  <= count_d;
         drop_q   <= drop_d;
         odata_q  <= odata_d;
         ovalid_q <= ovalid_d;
         osop_q   <= osop_d;
         oeop_q   <= oeop_d;
         perr_q   <= perr_d;
      end
   end

   assign oReady    = w_ready;
   assign oData     = odata_q;
   assign oValid    = ovalid_q;
   assign oSop      = osop_q;
   assign oEop      = oeop_q;
   assign oProtoErr = perr_q;

`ifdef CRC16_FRAME_STAT_EN
   logic [15:0] frame_cnt_q, frame_cnt_d;
   logic [15:0] err_cnt_q, err_cnt_d;
   logic [15:0] last_crc_q, last_crc_d;
   logic        w_trail_load, w_trail_xfer;

   assign w_trail_load = (state_q == ST_TRAIL) && w_out_free;
   assign w_trail_xfer = ovalid_q && oeop_q && iReady;

   always_comb begin
      frame_cnt_d = frame_cnt_q;
      err_cnt_d   = err_cnt_q;
      last_crc_d  = last_crc_q;
      if (w_trail_xfer && frame_cnt_q != 16'hFFFF) begin
         frame_cnt_d = frame_cnt_q + 16'd1;
      end
      if (perr_q && err_cnt_q != 16'hFFFF) begin
         err_cnt_d = err_cnt_q + 16'd1;
      end
      if (w_trail_load) begin
         last_crc_d = w_crc;
      end
   end

   always_ff @(posedge iClk or negedge iRst_n) begin
      if (!iRst_n) begin
         frame_cnt_q <= 16'd0;
         err_cnt_q   <= 16'd0;
         last_crc_q  <= CRC16_INIT;
      end else begin
         frame_cnt_q <= frame_cnt_d;
         err_cnt_q   <= err_cnt_d;
         last_crc_q  <= last_crc_d;
      end
   end

   assign oFrameCnt = frame_cnt_q;
   assign oErrCnt   = err_cnt_q;
   assign oLastCrc  = last_crc_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_crc16_frame_tx_ctrl.sv
`default_nettype none
// -----------------------------------------------------------------------------
// tb_crc16_frame_tx_ctrl : randomized self-checking bench with a division-based CRC model
// Revision: 1.0 - initial release
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_crc16_frame_tx_ctrl;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [31:0] in_data;
   logic        in_valid, in_sop, in_eop, eg_ready;
   logic        sel;
   logic        rand_rdy;

   logic        a_ready, a_valid, a_sop, a_eop, a_perr;
   logic        b_ready, b_valid, b_sop, b_eop, b_perr;
   logic [31:0] a_data, b_data;
`ifdef CRC16_FRAME_STAT_EN
   logic [15:0] a_frame_cnt, a_err_cnt, a_last_crc;
   logic [15:0] b_frame_cnt, b_err_cnt, b_last_crc;
`endif

   logic        o_ready, o_valid, o_sop, o_eop, o_perr;
   logic [31:0] o_data;
   assign o_ready = sel ? b_ready : a_ready;
   assign o_valid = sel ? b_valid : a_valid;
   assign o_sop   = sel ? b_sop   : a_sop;
   assign o_eop   = sel ? b_eop   : a_eop;
   assign o_perr  = sel ? b_perr  : a_perr;
   assign o_data  = sel ? b_data  : a_data;

   int n_err = 0;
   int n_chk = 0;
   int perr_cnt = 0;
   logic [33:0] got[$];
   logic [33:0] exp[$];

   always #5 clk = ~clk;

   crc16_frame_tx_ctrl #(.MAX_WORDS(380), .TRAIL_HI(1'b0)) dut_a (
      .iClk(clk), .iRst_n(rst_n), .iData(in_data), .iValid(in_valid), .iSop(in_sop),
      .iEop(in_eop), .oReady(a_ready), .oData(a_data), .oValid(a_valid), .oSop(a_sop),
      .oEop(a_eop), .iReady(eg_ready), .oProtoErr(a_perr)
`ifdef CRC16_FRAME_STAT_EN
      , .oFrameCnt(a_frame_cnt), .oErrCnt(a_err_cnt), .oLastCrc(a_last_crc)
`endif
   );

   crc16_frame_tx_ctrl #(.MAX_WORDS(8), .TRAIL_HI(1'b1)) dut_b (
      .iClk(clk), .iRst_n(rst_n), .iData(in_data), .iValid(in_valid), .iSop(in_sop),
      .iEop(in_eop), .oReady(b_ready), .oData(b_data), .oValid(b_valid), .oSop(b_sop),
      .oEop(b_eop), .iReady(eg_ready), .oProtoErr(b_perr)
`ifdef CRC16_FRAME_STAT_EN
      , .oFrameCnt(b_frame_cnt), .oErrCnt(b_err_cnt), .oLastCrc(b_last_crc)
`endif
   );

   // CRC as the remainder of polynomial long division by x^16+x^15+x^2+1,
   // with the all-ones preset folded into the first 16 message bits.
   function automatic logic [15:0] crc_model(input logic [31:0] w[$]);
      logic        bits[$];
      logic [16:0] rem;
      foreach (w[k]) for (int b = 31; b >= 0; b--) bits.push_back(w[k][b]);
      for (int i = 0; i < 16; i++) bits[i] = bits[i] ^ 1'b1;
      for (int i = 0; i < 16; i++) bits.push_back(1'b0);
      rem = 17'd0;
      foreach (bits[i]) begin
         rem = {rem[15:0], bits[i]};
         if (rem[16]) rem = rem ^ 17'h18005;
      end
      return rem[15:0];
   endfunction

   function automatic void push_frame(input logic [31:0] w[$], input bit hi);
      logic [15:0] c;
      c = crc_model(w);
      foreach (w[i]) exp.push_back({(i == 0), 1'b0, w[i]});
      exp.push_back({1'b0, 1'b1, (hi ? {c, 16'h0000} : {16'h0000, c})});
   endfunction

   // egress monitor: records transfers, counts error pulses, checks hold under stall
   initial begin
      logic        prev_stall;
      logic [33:0] prev_out;
      prev_stall = 1'b0;
      prev_out   = '0;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            prev_stall = 1'b0;
         end else begin
            if (prev_stall) begin
               n_chk++;
               if (o_valid !== 1'b1 || {o_sop, o_eop, o_data} !== prev_out) begin
                  n_err++;
                  $display("FAIL hold_stable: got v=%b %h required v=1 %h", o_valid, {o_sop, o_eop, o_data}, prev_out);
               end
            end
            if (o_valid && eg_ready) got.push_back({o_sop, o_eop, o_data});
            if (o_perr) perr_cnt++;
            prev_stall = o_valid && !eg_ready;
            prev_out   = {o_sop, o_eop, o_data};
         end
      end
   end

   initial begin
      forever begin
         @(posedge clk);
         #1;
         eg_ready = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
      end
   end

   task automatic send(input logic [31:0] d, input logic s, input logic e, inout int stalls);
      int n;
      n = 0;
      in_data = d; in_valid = 1'b1; in_sop = s; in_eop = e;
      forever begin
         @(negedge clk);
         if (o_ready) break;
         stalls++;
         n++;
         if (n > 200) begin
            n_chk++; n_err++;
            $display("FAIL send_timeout: word %h not accepted, required acceptance within 200 cycles", d);
            break;
         end
      end
      @(posedge clk);
      #1;
      in_valid = 1'b0; in_sop = 1'b0; in_eop = 1'b0;
   endtask

   task automatic send_frame(input logic [31:0] w[$], inout int stalls);
      foreach (w[i]) send(w[i], (i == 0), (i == w.size() - 1), stalls);
   endtask

   task automatic wait_drain();
      int n;
      n = 0;
      while (got.size() < exp.size() && n < 500) begin
         @(posedge clk);
         n++;
      end
      if (n >= 500) begin
         n_chk++; n_err++;
         $display("FAIL drain_timeout: got %0d egress words, required %0d", got.size(), exp.size());
      end
      repeat (6) @(posedge clk);
      #1;
   endtask

   task automatic clear_scoreboard();
      got.delete(); exp.delete(); perr_cnt = 0;
   endtask

   task automatic test_reset();
      #3;
      n_chk++;
      if ({a_valid, a_sop, a_eop, a_perr, a_data} !== 36'd0) begin
         n_err++;
         $display("FAIL reset_outputs: got v/s/e/err/data=%b%b%b%b %h required all zero", a_valid, a_sop, a_eop, a_perr, a_data);
      end
      n_chk++;
      if (a_ready !== 1'b1) begin
         n_err++; $display("FAIL reset_ready: got %b required 1", a_ready);
      end
`ifdef CRC16_FRAME_STAT_EN
      n_chk++;
      if (a_frame_cnt !== 16'd0 || a_err_cnt !== 16'd0 || a_last_crc !== 16'hFFFF) begin
         n_err++;
         $display("FAIL reset_stats: got %h %h %h required 0000 0000 ffff", a_frame_cnt, a_err_cnt, a_last_crc);
      end
`endif
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;
   endtask

   task automatic test_single();
      logic [31:0] w[$];
      int st;
      st = 0;
      clear_scoreboard();
      w.push_back(32'h12345678);
      push_frame(w, 1'b0);
      send_frame(w, st);
      wait_drain();
      n_chk++;
      if (got.size() !== exp.size()) begin
         n_err++; $display("FAIL single_count: got %0d words required %0d", got.size(), exp.size());
      end
      for (int i = 0; i < exp.size() && i < got.size(); i++) begin
         n_chk++;
         if (got[i] !== exp[i]) begin
            n_err++; $display("FAIL single_word%0d: got %h required %h", i, got[i], exp[i]);
         end
      end
   endtask

   task automatic test_back_to_back();
      logic [31:0] w[$];
      int st;
      st = 0;
      clear_scoreboard();
      for (int f = 0; f < 3; f++) begin
         w.delete();
         for (int i = 0; i < 4; i++) w.push_back($urandom);
         push_frame(w, 1'b0);
         send_frame(w, st);
      end
      wait_drain();
      n_chk++;
      if (got.size() !== 15) begin
         n_err++; $display("FAIL b2b_count: got %0d words required 15", got.size());
      end
      n_chk++;
      if (st !== 4) begin
         n_err++; $display("FAIL b2b_dead_cycles: got %0d stalled ingress cycles required 4", st);
      end
      for (int i = 0; i < exp.size() && i < got.size(); i++) begin
         n_chk++;
         if (got[i] !== exp[i]) begin
            n_err++; $display("FAIL b2b_word%0d: got %h required %h", i, got[i], exp[i]);
         end
      end
`ifdef CRC16_FRAME_STAT_EN
      n_chk++;
      if (a_frame_cnt !== 16'd4 || a_err_cnt !== 16'd0 || a_last_crc !== crc_model(w)) begin
         n_err++;
         $display("FAIL b2b_stats: got %0d %0d %h required 4 0 %h", a_frame_cnt, a_err_cnt, a_last_crc, crc_model(w));
      end
`endif
   endtask

   task automatic test_random_ready();
      logic [31:0] w[$];
      int st;
      st = 0;
      clear_scoreboard();
      rand_rdy = 1'b1;
      for (int i = 0; i < 10; i++) w.push_back($urandom);
      push_frame(w, 1'b0);
      send_frame(w, st);
      wait_drain();
      rand_rdy = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      n_chk++;
      if (got.size() !== 11) begin
         n_err++; $display("FAIL rndrdy_count: got %0d words required 11", got.size());
      end
      for (int i = 0; i < exp.size() && i < got.size(); i++) begin
         n_chk++;
         if (got[i] !== exp[i]) begin
            n_err++; $display("FAIL rndrdy_word%0d: got %h required %h", i, got[i], exp[i]);
         end
      end
   endtask

   task automatic test_missing_eop();
      logic [31:0] a[$];
      logic [31:0] b[$];
      int st;
      st = 0;
      clear_scoreboard();
      for (int i = 0; i < 2; i++) a.push_back($urandom);
      for (int i = 0; i < 4; i++) b.push_back($urandom);
      push_frame(a, 1'b0);
      push_frame(b, 1'b0);
      send(a[0], 1'b1, 1'b0, st);
      send(a[1], 1'b0, 1'b0, st);
      send_frame(b, st);
      wait_drain();
      n_chk++;
      if (perr_cnt !== 1) begin
         n_err++; $display("FAIL noeop_err_pulses: got %0d required 1", perr_cnt);
      end
      n_chk++;
      if (got.size() !== 8) begin
         n_err++; $display("FAIL noeop_count: got %0d words required 8", got.size());
      end
      for (int i = 0; i < exp.size() && i < got.size(); i++) begin
         n_chk++;
         if (got[i] !== exp[i]) begin
            n_err++; $display("FAIL noeop_word%0d: got %h required %h", i, got[i], exp[i]);
         end
      end
   endtask

   task automatic test_oversize();
      logic [31:0] w[$];
      logic [31:0] kept[$];
      logic [31:0] nxt[$];
      int st;
      st = 0;
      rst_n = 1'b0;
      sel = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      clear_scoreboard();
      for (int i = 0; i < 12; i++) w.push_back($urandom);
      for (int i = 0; i < 8; i++) kept.push_back(w[i]);
      for (int i = 0; i < 3; i++) nxt.push_back($urandom);
      push_frame(kept, 1'b1);
      push_frame(nxt, 1'b1);
      send_frame(w, st);
      send_frame(nxt, st);
      wait_drain();
      n_chk++;
      if (perr_cnt !== 1) begin
         n_err++; $display("FAIL oversize_err_pulses: got %0d required 1", perr_cnt);
      end
      n_chk++;
      if (got.size() !== 13) begin
         n_err++; $display("FAIL oversize_count: got %0d words required 13", got.size());
      end
      for (int i = 0; i < exp.size() && i < got.size(); i++) begin
         n_chk++;
         if (got[i] !== exp[i]) begin
            n_err++; $display("FAIL oversize_word%0d: got %h required %h", i, got[i], exp[i]);
         end
      end
      sel = 1'b0;
   endtask

   task automatic test_async_reset();
      int st;
      st = 0;
      rst_n = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;
      send($urandom, 1'b1, 1'b0, st);
      send($urandom, 1'b0, 1'b0, st);
      #2;
      rst_n = 1'b0;
      #1;
      n_chk++;
      if ({a_valid, a_sop, a_eop, a_perr, a_data} !== 36'd0) begin
         n_err++;
         $display("FAIL midreset_outputs: got v/s/e/err/data=%b%b%b%b %h required all zero", a_valid, a_sop, a_eop, a_perr, a_data);
      end
      @(posedge clk); #1;
      rst_n = 1'b1;
      clear_scoreboard();
      send($urandom, 1'b0, 1'b0, st);
      send($urandom, 1'b0, 1'b1, st);
      repeat (8) @(posedge clk);
      #1;
      n_chk++;
      if (got.size() !== 0) begin
         n_err++; $display("FAIL midreset_dropped: got %0d egress words required 0", got.size());
      end
      n_chk++;
      if (perr_cnt !== 2) begin
         n_err++; $display("FAIL midreset_err_pulses: got %0d required 2", perr_cnt);
      end
`ifdef CRC16_FRAME_STAT_EN
      n_chk++;
      if (a_err_cnt !== 16'd2 || a_frame_cnt !== 16'd0) begin
         n_err++; $display("FAIL midreset_stats: got err=%0d frames=%0d required 2 0", a_err_cnt, a_frame_cnt);
      end
`endif
   endtask

   initial begin
      rst_n = 1'b0; sel = 1'b0; rand_rdy = 1'b0; eg_ready = 1'b1;
      in_data = 32'd0; in_valid = 1'b0; in_sop = 1'b0; in_eop = 1'b0;
      test_reset();
      test_single();
      test_back_to_back();
      test_random_ready();
      test_missing_eop();
      test_oversize();
      test_async_reset();
      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
`default_nettype wire
